// File: rtl/gate_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// gate_window_gen_pkg
// Shared definitions for the gate-window generator and the windowed counter
// it feeds: default bus width and counter modulo, FSM state encoding, and a
// small helper used to size the window-length clamp.
// -----------------------------------------------------------------------------
package gate_window_gen_pkg;

    // Defaults shared with the downstream windowed counter.
    localparam int DEFAULT_BUS_SIZE = 8;
    localparam int DEFAULT_MODULO   = 100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GATE = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_window_gen_phase_down_counter.sv
// -----------------------------------------------------------------------------
// phase_down_counter
// BUS_SIZE-wide down-counter holding the cycles left in the current phase.
// Load has priority over Dec; Dec saturates at zero so the count never wraps.
//
// Ports:
//   Clk     in   1         clock, rising edge
//   Rst     in   1         asynchronous reset, active-high (count -> 0)
//   Load    in   1         load LoadVal on the next edge
//   LoadVal in   BUS_SIZE  value to load
//   Dec     in   1         decrement on the next edge (ignored at zero)
//   Cnt     out  BUS_SIZE  current count (registered)
//   Zero    out  1         Cnt == 0
// -----------------------------------------------------------------------------
module phase_down_counter
    import gate_window_gen_pkg::*;
#(
    parameter int BUS_SIZE = DEFAULT_BUS_SIZE
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Load,
    input  logic [BUS_SIZE-1:0] LoadVal,
    input  logic                Dec,
    output logic [BUS_SIZE-1:0] Cnt,
    output logic                Zero
);

    logic [BUS_SIZE-1:0] cnt_q;
    logic [BUS_SIZE-1:0] cnt_d;

    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (Load) begin
            cnt_d = LoadVal;
        end else if (Dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - BUS_SIZE'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cnt  = cnt_q;
    assign Zero = (cnt_q == '0);

endmodule

// File: rtl/gate_window_gen.sv
// -----------------------------------------------------------------------------
// gate_window_gen
// Programmable gate-window generator. Drives Gate high for L cycles then low
// for G cycles, once or repeatedly, where L = min(Len, MODULO-1) and
// G = max(Gap, 1). All outputs are registered on the rising edge of Clk so
// Gate is stable when a windowed counter samples it on the falling edge.
//
// Optional feature macro: GATE_WINDOW_GEN_ABORT_EN adds Abort/Aborted.
//
// Ports:
//   Clk     in   1         clock, rising edge
//   Rst     in   1         asynchronous reset, active-high
//   Start   in   1         start a sequence (only honoured in IDLE)
//   Len     in   BUS_SIZE  gate-high length, latched on accepted Start
//   Gap     in   BUS_SIZE  gate-low length, latched on accepted Start
//   Repeat  in   1         loop GATE/GAP; sampled at the end of each gap
//   Gate    out  1         window output
//   Busy    out  1         high in GATE or GAP
//   Done    out  1         one-cycle pulse when a sequence ends normally
//   Remain  out  BUS_SIZE  cycles left in the current phase minus one
//   Abort   in   1         (macro only) terminate the running sequence
//   Aborted out  1         (macro only) one-cycle pulse after an abort
// -----------------------------------------------------------------------------
module gate_window_gen
    import gate_window_gen_pkg::*;
#(
    parameter int BUS_SIZE = DEFAULT_BUS_SIZE,
    parameter int MODULO   = DEFAULT_MODULO
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [BUS_SIZE-1:0] Len,
    input  logic [BUS_SIZE-1:0] Gap,
    input  logic                Repeat,
    output logic                Gate,
    output logic                Busy,
    output logic                Done,
    output logic [BUS_SIZE-1:0] Remain
`ifdef GATE_WINDOW_GEN_ABORT_EN
    ,
    input  logic                Abort,
    output logic                Aborted
`endif
);

    // Longest window the downstream counter can hold, limited to what fits.
    localparam int                LEN_MAX_INT = min_int(MODULO - 1, (2 ** BUS_SIZE) - 1);
    localparam logic [BUS_SIZE-1:0] LEN_MAX   = BUS_SIZE'(LEN_MAX_INT);

    state_e              state_q, state_d;
    logic [BUS_SIZE-1:0] len_q, len_d;
    logic [BUS_SIZE-1:0] gap_q, gap_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BUS_SIZE-1:0] eff_len;
    logic [BUS_SIZE-1:0] eff_gap;
    logic                cnt_load;
    logic [BUS_SIZE-1:0] cnt_load_val;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [BUS_SIZE-1:0] cnt;
    logic                abort_hit;

    // Effective lengths: window clamped to the counter range, and at least one
    // low cycle so every window ends with a falling Gate.
    assign eff_len = (Len > LEN_MAX) ? LEN_MAX : Len;
    assign eff_gap = (Gap == '0) ? BUS_SIZE'(1) : Gap;

`ifdef GATE_WINDOW_GEN_ABORT_EN
    assign abort_hit = Abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // ---------------- state register (plus latched lengths and outputs) -----
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ---------------- next-state logic --------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    len_d = eff_len;
                    gap_d = eff_gap;
                    if (eff_len != '0) begin
                        state_d = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = Repeat ? ST_GATE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / counter-control logic ------------------------
    // Outputs are computed from the next state and registered, so nothing
    // reaches a port without passing through a flop.
    always_comb begin
        gate_d       = (state_d == ST_GATE);
        busy_d       = (state_d != ST_IDLE);
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (eff_len != '0) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = eff_len - BUS_SIZE'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_GATE, ST_GAP: begin
                if (abort_hit) begin
                    cnt_load = 1'b1;   // clear Remain
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (state_q == ST_GATE) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = gap_q - BUS_SIZE'(1);
                end else if (Repeat) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = len_q - BUS_SIZE'(1);
                end else begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    phase_down_counter #(
        .BUS_SIZE (BUS_SIZE)
    ) u_remain (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (cnt_load),
        .LoadVal (cnt_load_val),
        .Dec     (cnt_dec),
        .Cnt     (cnt),
        .Zero    (cnt_zero)
    );

`ifdef GATE_WINDOW_GEN_ABORT_EN
    logic aborted_q;
    logic aborted_d;

    assign aborted_d = abort_hit;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign Aborted = aborted_q;
`endif

    assign Gate   = gate_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Remain = cnt;

endmodule

// File: doc/gate_window_gen.md
Name: gate_window_gen

Overview:
Programmable gate-window generator: the source side of the windowed counting path.
- Drives Gate high for exactly Len clock cycles, then low for Gap cycles.
- Single-shot or repeating.
- Gate is produced on the Clk rising edge, so it is stable at the falling edge where the windowed counter samples it.
- Used to calibrate and exercise windowed counters, and as the timebase for frequency measurement.

Parameters:
BUS_SIZE, 8, width of Len, Gap and Remain.
MODULO, 100, modulo of the downstream counter; effective window length is clamped to MODULO-1.

Ports:
Clk     in   1          clock; all state updates on rising edge
Rst     in   1          asynchronous reset, active-high
Start   in   1          request a window sequence; sampled only in IDLE
Len     in   BUS_SIZE   gate-high length in cycles; latched on accepted Start
Gap     in   BUS_SIZE   gate-low length between windows; latched on accepted Start
Repeat  in   1          1 = loop GATE/GAP; sampled live at end of each gap
Gate    out  1          window output, registered
Busy    out  1          1 while in GATE or GAP
Done    out  1          one-cycle pulse when a sequence ends normally
Remain  out  BUS_SIZE   cycles left in current phase, including the present cycle minus one; 0 in IDLE

Behaviour:
- Reset: asynchronous and active-high, as already decided. Rst=1 forces state IDLE with Gate=0, Busy=0, Done=0, Remain=0, and clears the latched Len/Gap, immediately and regardless of Clk. Reset mid-window drops Gate at once.
- States: IDLE, GATE, GAP.
- Length rules:
  - Effective L = min(Len, MODULO-1).
  - Effective G = max(Gap, 1): at least one low cycle, so the downstream memory always sees a falling gate.
- IDLE:
  - Start=1 and L>0 at edge k: after edge k, Gate=1, Busy=1, Remain=L-1, state GATE.
  - Start=1 and L=0: Done=1 for one cycle, Gate stays 0, no Busy.
- GATE:
  - Remain decrements each edge.
  - On the edge where Remain=0: state GAP, Gate=0, Remain=G-1.
  - Gate is high for exactly L consecutive cycles (edges k .. k+L-1).
- GAP:
  - Remain decrements each edge.
  - On the edge where Remain=0 and Repeat=1: state GATE, Gate=1, Remain=L-1, using the latched L.
  - On the edge where Remain=0 and Repeat=0: state IDLE, Done=1 for one cycle, Busy=0.
- Start while Busy is ignored, and Len/Gap changes during Busy are ignored.
- Start is accepted on the edge right after Done, i.e. back-to-back sequences are allowed.
- Done and Gate are never high in the same cycle.
- All outputs are registered; no combinational input-to-output path.
- Remain width is BUS_SIZE. Arithmetic never underflows: decrement only when Remain>0.

Optional Feature:
Macro GATE_WINDOW_GEN_ABORT_EN.
- With the macro defined:
  - Extra input Abort (1 bit) and output Aborted (1 bit, reset 0).
  - Abort=1 sampled in GATE or GAP: next edge gives state IDLE, Gate=0, Busy=0, Remain=0, Aborted=1 for one cycle, Done=0.
  - Abort in IDLE has no effect.
  - If Abort and a phase end coincide, Abort wins.
- Without the macro: neither port exists, and a sequence always runs to Done or Rst.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'b00, GATE=2'b01, GAP=2'b10.
  - default BUS_SIZE and MODULO constants, shared with the windowed counter.
- One natural sub-module, phase_down_counter, which is the BUS_SIZE down-counter used for Remain:
  - Ports: Clk, Rst, Load, LoadVal, Dec → Cnt, Zero.
  - Parameterised by BUS_SIZE.
  - Instantiated once; the FSM drives Load/LoadVal.

Test Plan:
- Single shot: Rst pulse, Len=5, Gap=3, Repeat=0, Start for 1 cycle → Gate high exactly 5 cycles, low 3, Done pulse 1 cycle after, Busy high 8 cycles; chained windowed counter memorises 5.
- Repeat: Len=4, Gap=2, Repeat=1 → period-6 waveform, Gate high 4 of every 6 cycles, no Done. Drop Repeat mid-window → current gap completes, then Done.
- Clamp and minimum gap: MODULO=100, Len=200, Gap=0 → Gate high 99 cycles, low 1 cycle, then Done.
- Degenerate and ignored requests: Len=0 with Start → Done only, Gate never high. Start pulses during Busy, and Len changed to 9 mid-sequence → no effect on the running 5-cycle window.
- Async reset: assert Rst between clock edges at cycle 3 of a Len=10 window → Gate, Busy and Remain go to 0 immediately. After release, Start works normally.
- Abort, only when GATE_WINDOW_GEN_ABORT_EN is defined: Abort at cycle 2 of Len=6 → Gate low next edge, Aborted pulses 1 cycle, no Done. Abort coinciding with the last gap cycle → Aborted, not Done.
